mul_exec_unit: RTL and testbench

Iterative 32-bit multiply execution unit that sits directly downstream of the multiply reservation station (station ID 2'b10). It accepts one ready instruction at a time: opcode, two resolved operands and the 4-bit station label. It computes the product over a fixed number of cycles, then holds the result and label on a request line until the common data bus (CDB) grants the broadcast. It returns to idle on grant, which is the same edge on which the reservation station frees the entry.

---
 rtl/mul_exec_unit_if.sv | 32 +++
 rtl/mul_exec_unit.sv | 139 +++++++++++++
 tb/tb_mul_exec_unit.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mul_exec_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_exec_unit_if
// Description : Issue and CDB handshake bundle between the multiply
//               reservation station / CDB arbiter and mul_exec_unit.
// Revision    : 1.0  initial release
// ============================================================================
interface mul_exec_unit_if;
    logic        OutEn;
    logic [2:0]  opIn;
    logic [31:0] dataIn1;
    logic [31:0] dataIn2;
    logic [3:0]  labelIn;
    logic        EXEable;
    logic        reqCDB;
    logic        grantCDB;
    logic [31:0] dataOut;
    logic [3:0]  labelOut;

    // Station / arbiter side
    modport master (
        output OutEn, opIn, dataIn1, dataIn2, labelIn, grantCDB,
        input  EXEable, reqCDB, dataOut, labelOut
    );

    // Execution unit side
    modport slave (
        input  OutEn, opIn, dataIn1, dataIn2, labelIn, grantCDB,
        output EXEable, reqCDB, dataOut, labelOut
    );
endinterface
`default_nettype wire

// File: rtl/mul_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_exec_unit
// Description : Iterative radix-2 32x32 multiply unit (MUL/MULH/MULHU/MULHSU)
//               holding its result on the CDB request line until granted.
// Revision    : 1.0  initial release
// ============================================================================
module mul_exec_unit (
    input  wire logic      clk,
    input  wire logic      RST,
    mul_exec_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [4:0] c_LAST_ITER = 5'd31;
    localparam logic [2:0] c_OP_MUL    = 3'b000;
    localparam logic [2:0] c_OP_MULH   = 3'b001;
    localparam logic [2:0] c_OP_MULHU  = 3'b010;
    localparam logic [2:0] c_OP_MULHSU = 3'b011;

    state_t      r_state;
    logic [63:0] r_mcand;
    logic [31:0] r_mplier;
    logic [63:0] r_acc;
    logic [4:0]  r_cnt;
    logic        r_neg;
    logic [2:0]  r_op;
    logic [3:0]  r_label;
    logic        r_exeAble;
    logic        r_reqCdb;
    logic [31:0] r_dataOut;
    logic [3:0]  r_labelOut;

    logic        w_aSigned;
    logic        w_bSigned;
    logic        w_aNeg;
    logic        w_bNeg;
    logic [31:0] w_magA;
    logic [31:0] w_magB;
    logic [63:0] w_accNext;
    logic [63:0] w_fixed;
    logic [31:0] w_result;

    // Operands are multiplied as magnitudes; the sign is restored in FIX.
    assign w_aSigned = (bus.opIn == c_OP_MULH) || (bus.opIn == c_OP_MULHSU);
    assign w_bSigned = (bus.opIn == c_OP_MULH);
    assign w_aNeg    = w_aSigned & bus.dataIn1[31];
    assign w_bNeg    = w_bSigned & bus.dataIn2[31];
    assign w_magA    = w_aNeg ? (~bus.dataIn1 + 32'd1) : bus.dataIn1;
    assign w_magB    = w_bNeg ? (~bus.dataIn2 + 32'd1) : bus.dataIn2;

    assign w_accNext = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_fixed   = r_neg ? (~r_acc + 64'd1) : r_acc;

    always_comb begin
        w_result = 32'h0;
        case (r_op)
            c_OP_MUL:    w_result = w_fixed[31:0];
            c_OP_MULH,
            c_OP_MULHU,
            c_OP_MULHSU: w_result = w_fixed[63:32];
            default:     w_result = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_mcand    <= 64'd0;
            r_mplier   <= 32'd0;
            r_acc      <= 64'd0;
            r_cnt      <= 5'd0;
            r_neg      <= 1'b0;
            r_op       <= 3'd0;
            r_label    <= 4'd0;
            r_exeAble  <= 1'b1;
            r_reqCdb   <= 1'b0;
            r_dataOut  <= 32'd0;
            r_labelOut <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.OutEn) begin
                        r_op      <= bus.opIn;
                        r_label   <= bus.labelIn;
                        r_mcand   <= {32'd0, w_magA};
                        r_mplier  <= w_magB;
                        r_neg     <= w_aNeg ^ w_bNeg;
                        r_acc     <= 64'd0;
                        r_cnt     <= 5'd0;
                        r_exeAble <= 1'b0;
                        r_state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc    <= w_accNext;
                    r_mcand  <= {r_mcand[62:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[31:1]};
                    r_cnt    <= r_cnt + 5'd1;
                    if (r_cnt == c_LAST_ITER) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_dataOut  <= w_result;
                    r_labelOut <= r_label;
                    r_reqCdb   <= 1'b1;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    // The station frees the entry on this same grant edge.
                    if (bus.grantCDB) begin
                        r_reqCdb  <= 1'b0;
                        r_exeAble <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_reqCdb  <= 1'b0;
                    r_exeAble <= 1'b1;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.EXEable  = r_exeAble;
    assign bus.reqCDB   = r_reqCdb;
    assign bus.dataOut  = r_dataOut;
    assign bus.labelOut = r_labelOut;

endmodule
`default_nettype wire

// File: tb/tb_mul_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_exec_unit
// Description : Directed self-checking bench for mul_exec_unit.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mul_exec_unit;

    logic clk = 1'b0;
    logic RST;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   acceptCyc;
    int   grantCyc;
    int   lat;

    mul_exec_unit_if bus();

    mul_exec_unit dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every task below returns at a negedge sample point or just after an edge.
    task automatic doReset();
        RST = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 RST = 1'b0;
        @(negedge clk);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] lbl);
        int n = 0;
        while (!bus.EXEable && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("exeable_timeout", 64'd0, 64'd1);
        bus.opIn    = op;
        bus.dataIn1 = a;
        bus.dataIn2 = b;
        bus.labelIn = lbl;
        bus.OutEn   = 1'b1;
        @(posedge clk);
        #1;
        acceptCyc = cyc;
        bus.OutEn = 1'b0;
    endtask

    task automatic waitReq(output int n);
        n = 0;
        @(negedge clk);
        while (!bus.reqCDB && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic grantNow(input string tag);
        bus.grantCDB = 1'b1;
        @(posedge clk);
        #1;
        grantCyc     = cyc;
        bus.grantCDB = 1'b0;
        @(negedge clk);
        check({tag, "_exeable_after_grant"}, 64'(bus.EXEable), 64'd1);
        check({tag, "_req_after_grant"}, 64'(bus.reqCDB), 64'd0);
    endtask

    task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] lbl, input logic [31:0] expData);
        int n;
        issue(op, a, b, lbl);
        waitReq(n);
        check({tag, "_latency"}, 64'(n), 64'd33);
        check({tag, "_data"}, 64'(bus.dataOut), 64'(expData));
        check({tag, "_label"}, 64'(bus.labelOut), 64'(lbl));
        grantNow(tag);
    endtask

    initial begin
        bus.OutEn    = 1'b0;
        bus.opIn     = 3'd0;
        bus.dataIn1  = 32'd0;
        bus.dataIn2  = 32'd0;
        bus.labelIn  = 4'd0;
        bus.grantCDB = 1'b0;
        doReset();

        check("reset_exeable", 64'(bus.EXEable), 64'd1);
        check("reset_req", 64'(bus.reqCDB), 64'd0);
        check("reset_data", 64'(bus.dataOut), 64'd0);
        check("reset_label", 64'(bus.labelOut), 64'd0);

        runOp("mul_basic", 3'b000, 32'd7, 32'd6, 4'b1000, 32'd42);
        runOp("mulh_min_x2", 3'b001, 32'h8000_0000, 32'd2, 4'h1, 32'hFFFF_FFFF);
        runOp("mulh_m1_m1", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h2, 32'h0000_0000);
        runOp("mul_m1_x3", 3'b000, 32'hFFFF_FFFF, 32'd3, 4'h3, 32'hFFFF_FFFD);
        runOp("mulhu_max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h4, 32'hFFFF_FFFE);
        runOp("mulhsu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h5, 32'hFFFF_FFFF);
        runOp("reserved", 3'b101, 32'd5, 32'd7, 4'h6, 32'h0);

        // Delayed grant with a competing issue held on the bus throughout.
        issue(3'b000, 32'd9, 32'd11, 4'hA);
        waitReq(lat);
        check("hold_latency", 64'(lat), 64'd33);
        bus.opIn    = 3'b000;
        bus.dataIn1 = 32'd2;
        bus.dataIn2 = 32'd2;
        bus.labelIn = 4'h3;
        bus.OutEn   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_stable", {26'd0, bus.reqCDB, bus.EXEable, bus.labelOut, bus.dataOut},
                  {26'd0, 1'b1, 1'b0, 4'hA, 32'd99});
        end
        bus.grantCDB = 1'b1;
        @(posedge clk);
        #1 bus.grantCDB = 1'b0;
        @(negedge clk);
        check("hold_exeable_after_grant", 64'(bus.EXEable), 64'd1);
        @(posedge clk);
        #1 bus.OutEn = 1'b0;
        waitReq(lat);
        check("held_issue_latency", 64'(lat), 64'd33);
        check("held_issue_data", 64'(bus.dataOut), 64'd4);
        check("held_issue_label", 64'(bus.labelOut), 64'h3);
        grantNow("held_issue");

        // Reset during CALC iteration 15.
        issue(3'b000, 32'h1234, 32'h5678, 4'h9);
        repeat (15) @(posedge clk);
        #1 RST = 1'b1;
        @(posedge clk);
        #1 RST = 1'b0;
        @(negedge clk);
        check("midrst_exeable", 64'(bus.EXEable), 64'd1);
        check("midrst_req", 64'(bus.reqCDB), 64'd0);
        check("midrst_data", 64'(bus.dataOut), 64'd0);
        check("midrst_label", 64'(bus.labelOut), 64'd0);
        runOp("after_rst", 3'b000, 32'd3, 32'd5, 4'hC, 32'd15);

        // Back-to-back issues, grant in the first DONE cycle each time.
        runOp("b2b_first", 3'b000, 32'd100, 32'd200, 4'hD, 32'd20000);
        issue(3'b010, 32'h0001_0000, 32'h0003_0000, 4'hE);
        check("b2b_accept_after_grant", 64'(acceptCyc - grantCyc), 64'd1);
        waitReq(lat);
        check("b2b_second_latency", 64'(lat), 64'd33);
        check("b2b_second_data", 64'(bus.dataOut), 64'd3);
        check("b2b_second_label", 64'(bus.labelOut), 64'hE);
        grantNow("b2b_second");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
